maxpool2: RTL and testbench

Downstream stage of the 3x3 sliding-window convolution block. Consumes the full convolution feature map and its done level, then performs non-overlapping POOLxPOOL max pooling, one element per cycle. Writes a pooled feature map and raises its own done level for the next layer (flatten/dense or a second conv stage).

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pool_max_cmp.sv | 26 ++
 rtl/maxpool2.sv | 134 +++++++++++++
 tb/tb_maxpool2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: types and helpers shared by the CNN layer blocks.
//   pool_state_e  - pooling sequencer states
//   elem_t        - feature-map element at the default 8-bit width
//   pool_out_dim  - pooled map edge for a given input edge and pool window
//   idx_width     - counter width able to index 0..n-1 (at least 1 bit)
package cnn_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StWrite} pool_state_e;

   // Packages cannot take parameters; blocks that vary the width declare their own vectors.
   localparam int unsigned ElemWidth = 8;
   typedef logic [ElemWidth-1:0] elem_t;

   function automatic int unsigned pool_out_dim(input int unsigned size, input int unsigned pool);
      return size / pool;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_max_cmp.sv
// pool_max_cmp: combinational two-input maximum.
//   a, b  - operands, WIDTH_BIT bits
//   y     - the larger operand (pure select, no widening)
// SIGNED = 0 compares unsigned, SIGNED = 1 compares two's complement.
module pool_max_cmp #(
   parameter int unsigned WIDTH_BIT = 8,
   parameter int unsigned SIGNED    = 0
) (
   input  logic [WIDTH_BIT-1:0] a,
   input  logic [WIDTH_BIT-1:0] b,
   output logic [WIDTH_BIT-1:0] y
);

   logic b_gt_a;

   always_comb begin
      if (SIGNED != 0) begin
         b_gt_a = $signed(b) > $signed(a);
      end else begin
         b_gt_a = b > a;
      end
      // Equal operands select a; both carry the same value.
      y = b_gt_a ? b : a;
   end

endmodule

// File: rtl/maxpool2.sv
// maxpool2: non-overlapping POOLxPOOL max pooling over a SIZExSIZE feature map,
// one element per clock.
//   clock   - rising-edge clock
//   nreset  - asynchronous active-low reset
//   start   - level; a run begins on its rising edge while idle
//   featIn  - input feature map, captured on the accepted start edge
//   busy    - high while a run is in progress
//   done    - high from the last write until the next accepted start edge
//   poolOut - pooled map, registered, held until overwritten
module maxpool2
   import cnn_pkg::*;
#(
   parameter int unsigned SIZE      = 5,
   parameter int unsigned POOL      = 2,
   parameter int unsigned WIDTH_BIT = 8,
   parameter int unsigned SIGNED    = 0,
   localparam int unsigned OUT      = pool_out_dim(SIZE, POOL)
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic                 start,
   input  logic [WIDTH_BIT-1:0] featIn  [SIZE][SIZE],
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH_BIT-1:0] poolOut [OUT][OUT]
);

   localparam int unsigned OW = idx_width(OUT);
   localparam int unsigned PW = idx_width(POOL);
   localparam int unsigned RW = idx_width(SIZE);

   pool_state_e          state;
   logic                 start_q;
   logic [OW-1:0]        oi, oj;
   logic [PW-1:0]        r, c;
   logic [WIDTH_BIT-1:0] acc;
   logic [WIDTH_BIT-1:0] snapshot [SIZE][SIZE];

   logic [RW-1:0]        row, col;
   logic [WIDTH_BIT-1:0] elem, acc_max;
   logic                 start_edge, first_elem, last_elem, last_col, last_window;

   always_comb begin
      row         = RW'(32'(oi) * POOL + 32'(r));
      col         = RW'(32'(oj) * POOL + 32'(c));
      elem        = snapshot[row][col];
      start_edge  = start && !start_q && (state == StIdle);
      first_elem  = (r == '0) && (c == '0);
      last_col    = (c == PW'(POOL - 1));
      last_elem   = (r == PW'(POOL - 1)) && last_col;
      last_window = (oi == OW'(OUT - 1)) && (oj == OW'(OUT - 1));
   end

   pool_max_cmp #(
      .WIDTH_BIT (WIDTH_BIT),
      .SIGNED    (SIGNED)
   ) u_cmp (
      .a (acc),
      .b (elem),
      .y (acc_max)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state   <= StIdle;
         start_q <= 1'b0;
         oi      <= '0;
         oj      <= '0;
         r       <= '0;
         c       <= '0;
         acc     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < OUT; i++) begin
            for (int j = 0; j < OUT; j++) begin
               poolOut[i][j] <= '0;
            end
         end
         for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
               snapshot[i][j] <= '0;
            end
         end
      end else begin
         start_q <= start;
         unique case (state)
            StIdle: begin
               if (start_edge) begin
                  // Capture the map so upstream may move on during the run.
                  snapshot <= featIn;
                  oi       <= '0;
                  oj       <= '0;
                  r        <= '0;
                  c        <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state    <= StScan;
               end
            end
            StScan: begin
               acc <= first_elem ? elem : acc_max;
               if (last_elem) begin
                  r     <= '0;
                  c     <= '0;
                  state <= StWrite;
               end else if (last_col) begin
                  c <= '0;
                  r <= r + PW'(1);
               end else begin
                  c <= c + PW'(1);
               end
            end
            StWrite: begin
               poolOut[oi][oj] <= acc;
               if (oj == OW'(OUT - 1)) begin
                  oj <= '0;
                  oi <= oi + OW'(1);
               end else begin
                  oj <= oj + OW'(1);
               end
               if (last_window) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  state <= StScan;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool2.sv
// tb_maxpool2: directed and randomized runs of maxpool2, unsigned and signed
// instances side by side, checked against a window-by-window maximum model.
module tb_maxpool2;

   localparam int SIZE = 5;
   localparam int POOL = 2;
   localparam int W    = 8;
   localparam int OUT  = SIZE / POOL;

   logic         clock = 1'b0;
   logic         nreset;
   logic         start;
   logic [W-1:0] featIn   [SIZE][SIZE];
   logic [W-1:0] feat_ref [SIZE][SIZE];
   logic         busy_u, done_u, busy_s, done_s;
   logic [W-1:0] pool_u [OUT][OUT];
   logic [W-1:0] pool_s [OUT][OUT];
   logic [W-1:0] exp_u  [OUT][OUT];
   logic [W-1:0] exp_s  [OUT][OUT];

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   maxpool2 #(
      .SIZE      (SIZE),
      .POOL      (POOL),
      .WIDTH_BIT (W),
      .SIGNED    (0)
   ) dut_u (
      .clock   (clock),
      .nreset  (nreset),
      .start   (start),
      .featIn  (featIn),
      .busy    (busy_u),
      .done    (done_u),
      .poolOut (pool_u)
   );

   maxpool2 #(
      .SIZE      (SIZE),
      .POOL      (POOL),
      .WIDTH_BIT (W),
      .SIGNED    (1)
   ) dut_s (
      .clock   (clock),
      .nreset  (nreset),
      .start   (start),
      .featIn  (featIn),
      .busy    (busy_s),
      .done    (done_s),
      .poolOut (pool_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Maximum of each window, compared as plain integers in both interpretations.
   task automatic compute_model();
      for (int oi = 0; oi < OUT; oi++) begin
         for (int oj = 0; oj < OUT; oj++) begin
            int best_u;
            int best_s;
            best_u = -1;
            best_s = -1000;
            for (int r = 0; r < POOL; r++) begin
               for (int c = 0; c < POOL; c++) begin
                  logic [W-1:0] v;
                  v = feat_ref[oi*POOL+r][oj*POOL+c];
                  if (int'(v) > best_u) best_u = int'(v);
                  if (int'($signed(v)) > best_s) best_s = int'($signed(v));
               end
            end
            exp_u[oi][oj] = W'(best_u);
            exp_s[oi][oj] = W'(best_s);
         end
      end
   endtask

   // mode 0 ramp, 1 random, 2 signed window, 3 all 0x7F with one stray corner
   task automatic load(input int mode);
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            case (mode)
               0:       feat_ref[r][c] = W'(r * SIZE + c);
               1:       feat_ref[r][c] = W'($urandom);
               2:       feat_ref[r][c] = '0;
               default: feat_ref[r][c] = 8'h7F;
            endcase
         end
      end
      if (mode == 2) begin
         feat_ref[0][0] = 8'hFF;
         feat_ref[0][1] = 8'h01;
         feat_ref[1][0] = 8'h80;
         feat_ref[1][1] = 8'h00;
      end
      if (mode == 3) feat_ref[4][4] = 8'hC8;
      featIn = feat_ref;
      compute_model();
   endtask

   task automatic check_maps(input string tag);
      for (int i = 0; i < OUT; i++) begin
         for (int j = 0; j < OUT; j++) begin
            check($sformatf("%s u[%0d][%0d]", tag, i, j), 32'(pool_u[i][j]), 32'(exp_u[i][j]));
            check($sformatf("%s s[%0d][%0d]", tag, i, j), 32'(pool_s[i][j]), 32'(exp_s[i][j]));
         end
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check($sformatf("%s busy_u", tag), 32'(busy_u), 32'd0);
      check($sformatf("%s busy_s", tag), 32'(busy_s), 32'd0);
      check($sformatf("%s done_u", tag), 32'(done_u), 32'd0);
      check($sformatf("%s done_s", tag), 32'(done_s), 32'd0);
      for (int i = 0; i < OUT; i++) begin
         for (int j = 0; j < OUT; j++) begin
            check($sformatf("%s zero u[%0d][%0d]", tag, i, j), 32'(pool_u[i][j]), 32'd0);
            check($sformatf("%s zero s[%0d][%0d]", tag, i, j), 32'(pool_s[i][j]), 32'd0);
         end
      end
   endtask

   // One run from a fresh rising start edge. glitch > 0 pulses start at that
   // cycle of the run; hold keeps start high throughout.
   task automatic run(input string tag, input int glitch, input bit hold);
      int n;
      bit busy_ok;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("%s busy_u@E0", tag), 32'(busy_u), 32'd1);
      check($sformatf("%s busy_s@E0", tag), 32'(busy_s), 32'd1);
      check($sformatf("%s done_u@E0", tag), 32'(done_u), 32'd0);
      // The captured map must be used, not the live input.
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            featIn[r][c] = W'($urandom);
         end
      end
      n = 0;
      busy_ok = 1'b1;
      while (n < 40) begin
         @(negedge clock);
         n++;
         if (!hold) start = (n == glitch);
         @(posedge clock);
         #1;
         if (done_u || done_s) break;
         if (busy_u !== 1'b1 || busy_s !== 1'b1) busy_ok = 1'b0;
      end
      check($sformatf("%s done latency", tag), 32'(n), 32'd20);
      check($sformatf("%s busy held", tag), 32'(busy_ok), 32'd1);
      check($sformatf("%s done_u", tag), 32'(done_u), 32'd1);
      check($sformatf("%s done_s", tag), 32'(done_s), 32'd1);
      check($sformatf("%s busy_u end", tag), 32'(busy_u), 32'd0);
      check($sformatf("%s busy_s end", tag), 32'(busy_s), 32'd0);
      check_maps(tag);
   endtask

   initial begin
      bit stay_ok;
      nreset = 1'b0;
      start  = 1'b0;
      load(3);
      #12;
      check_idle_zero("reset");
      @(negedge clock);
      nreset = 1'b1;
      @(posedge clock);
      #1;
      check("idle after release", 32'(busy_u), 32'd0);

      load(0);
      run("ramp", 0, 1'b0);
      check("ramp const [0][0]", 32'(pool_u[0][0]), 32'd6);
      check("ramp const [0][1]", 32'(pool_u[0][1]), 32'd8);
      check("ramp const [1][0]", 32'(pool_u[1][0]), 32'd16);
      check("ramp const [1][1]", 32'(pool_u[1][1]), 32'd18);

      load(2);
      run("signed", 0, 1'b0);
      check("signed const s", 32'(pool_s[0][0]), 32'h01);
      check("signed const u", 32'(pool_u[0][0]), 32'hFF);

      load(3);
      run("odd edge", 0, 1'b0);
      check("odd const", 32'(pool_u[1][1]), 32'h7F);

      load(0);
      run("glitch", 8, 1'b0);

      load(1);
      run("hold", 0, 1'b1);
      stay_ok = 1'b1;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (!(done_u && done_s && !busy_u && !busy_s)) stay_ok = 1'b0;
      end
      check("hold single run", 32'(stay_ok), 32'd1);
      load(1);
      run("rerun", 0, 1'b0);

      // Abort a run at cycle 10 with an asynchronous reset.
      load(0);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      repeat (10) @(posedge clock);
      #2;
      check("midrun busy", 32'(busy_u), 32'd1);
      nreset = 1'b0;
      start  = 1'b0;
      #1;
      check_idle_zero("midrun reset");
      @(negedge clock);
      nreset = 1'b1;
      load(1);
      run("after reset", 0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         load(1);
         run($sformatf("rand%0d", t), 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
